// File: rtl/cfs_md_rx_pkg.sv
// Shared types and width helpers for the MD RX control block.
package cfs_md_rx_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PUSH = 2'd1,
    RESP = 2'd2
  } state_t;

  function automatic int offset_width(input int data_width);
    int bytes;
    bytes = data_width / 8;
    return ($clog2(bytes) > 1) ? $clog2(bytes) : 1;
  endfunction

  function automatic int size_width(input int data_width);
    return $clog2(data_width / 8) + 1;
  endfunction

endpackage

// File: rtl/cfs_md_rx_legal_chk.sv
// Combinational MD transfer legality check: size!=0, fits in the bus word,
// and (BYTES+offset) is a multiple of size.
module cfs_md_rx_legal_chk
  import cfs_md_rx_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  localparam int OFFSET_WIDTH = offset_width(DATA_WIDTH),
  localparam int SIZE_WIDTH   = size_width(DATA_WIDTH)
) (
  input  logic [OFFSET_WIDTH-1:0] offset,
  input  logic [SIZE_WIDTH-1:0]   size,
  output logic                    legal
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int SUM_W = SIZE_WIDTH + 1;

  logic [SUM_W-1:0] end_sum;
  logic [SUM_W-1:0] base_sum;
  logic [SUM_W-1:0] divisor;
  logic [SUM_W-1:0] rem;

  // One extra bit keeps offset+size from wrapping back into the legal range.
  assign end_sum  = SUM_W'(offset) + SUM_W'(size);
  assign base_sum = SUM_W'(BYTES) + SUM_W'(offset);
  assign divisor  = (size == '0) ? SUM_W'(1) : SUM_W'(size);
  assign rem      = base_sum % divisor;

  assign legal = (size != '0) && (end_sum <= SUM_W'(BYTES)) && (rem == '0);

endmodule

// File: rtl/cfs_md_rx_ctrl.sv
// MD slave endpoint at the aligner RX input: checks transfers, pushes legal ones
// to the RX FIFO. Optional illegal-transfer counter under `CFS_MD_RX_ERR_CNT_EN.
module cfs_md_rx_ctrl
  import cfs_md_rx_pkg::*;
#(
  parameter int DATA_WIDTH = 32
`ifdef CFS_MD_RX_ERR_CNT_EN
  , parameter int ERR_CNT_WIDTH = 8
`endif
  , localparam int OFFSET_WIDTH = offset_width(DATA_WIDTH)
  , localparam int SIZE_WIDTH   = size_width(DATA_WIDTH)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    md_valid,
  input  logic [DATA_WIDTH-1:0]   md_data,
  input  logic [OFFSET_WIDTH-1:0] md_offset,
  input  logic [SIZE_WIDTH-1:0]   md_size,
  output logic                    md_ready,
  output logic                    md_err,
  output logic                    push_valid,
  output logic [DATA_WIDTH-1:0]   push_data,
  output logic [OFFSET_WIDTH-1:0] push_offset,
  output logic [SIZE_WIDTH-1:0]   push_size,
  input  logic                    push_ready,
  output logic                    err_pulse
`ifdef CFS_MD_RX_ERR_CNT_EN
  , input  logic                     err_cnt_clr
  , output logic [ERR_CNT_WIDTH-1:0] err_cnt
`endif
);

  state_t state, state_nx;
  logic   legal;
  logic   cap_en;
  logic   err_q, err_nx;

  cfs_md_rx_legal_chk #(.DATA_WIDTH(DATA_WIDTH)) u_legal_chk (
    .offset (md_offset),
    .size   (md_size),
    .legal  (legal)
  );

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_nx = state;
    cap_en   = 1'b0;
    case (state)
      IDLE: if (md_valid) begin
        cap_en   = 1'b1;
        state_nx = legal ? PUSH : RESP;
      end
      PUSH:    if (push_ready) state_nx = RESP;
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    err_nx = cap_en ? ~legal : err_q;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      err_q       <= 1'b0;
      push_data   <= '0;
      push_offset <= '0;
      push_size   <= '0;
      push_valid  <= 1'b0;
      md_ready    <= 1'b0;
      md_err      <= 1'b0;
      err_pulse   <= 1'b0;
    end else begin
      state <= state_nx;
      err_q <= err_nx;
      if (cap_en) begin
        push_data   <= md_data;
        push_offset <= md_offset;
        push_size   <= md_size;
      end
      // Outputs are registered from the next state so they line up with it.
      push_valid <= (state_nx == PUSH);
      md_ready   <= (state_nx == RESP);
      md_err     <= (state_nx == RESP) && err_nx;
      err_pulse  <= (state_nx == RESP) && err_nx;
    end
  end

`ifdef CFS_MD_RX_ERR_CNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_cnt <= '0;
    end else if (err_cnt_clr) begin
      err_cnt <= '0;
    end else if (err_pulse && (err_cnt != '1)) begin
      err_cnt <= err_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_cfs_md_rx_ctrl.sv
// Directed self-checking bench for cfs_md_rx_ctrl (DATA_WIDTH=32, BYTES=4).
module tb_cfs_md_rx_ctrl;

  localparam int DW = 32;

  logic        clk = 1'b0;
  logic        reset;
  logic        md_valid;
  logic [31:0] md_data;
  logic [1:0]  md_offset;
  logic [2:0]  md_size;
  logic        md_ready;
  logic        md_err;
  logic        push_valid;
  logic [31:0] push_data;
  logic [1:0]  push_offset;
  logic [2:0]  push_size;
  logic        push_ready;
  logic        err_pulse;
`ifdef CFS_MD_RX_ERR_CNT_EN
  logic        err_cnt_clr;
  logic [1:0]  err_cnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cfs_md_rx_ctrl #(
    .DATA_WIDTH(DW)
`ifdef CFS_MD_RX_ERR_CNT_EN
    , .ERR_CNT_WIDTH(2)
`endif
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .md_valid    (md_valid),
    .md_data     (md_data),
    .md_offset   (md_offset),
    .md_size     (md_size),
    .md_ready    (md_ready),
    .md_err      (md_err),
    .push_valid  (push_valid),
    .push_data   (push_data),
    .push_offset (push_offset),
    .push_size   (push_size),
    .push_ready  (push_ready),
    .err_pulse   (err_pulse)
`ifdef CFS_MD_RX_ERR_CNT_EN
    , .err_cnt_clr (err_cnt_clr)
    , .err_cnt     (err_cnt)
`endif
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic [31:0] d, input logic [1:0] off, input logic [2:0] sz);
    md_valid  = 1'b1;
    md_data   = d;
    md_offset = off;
    md_size   = sz;
  endtask

  task automatic test_reset();
    checks++; if (md_ready !== 1'b0) begin errors++; $display("FAIL reset_md_ready got=%b exp=0", md_ready); end
    checks++; if (md_err !== 1'b0) begin errors++; $display("FAIL reset_md_err got=%b exp=0", md_err); end
    checks++; if (push_valid !== 1'b0) begin errors++; $display("FAIL reset_push_valid got=%b exp=0", push_valid); end
    checks++; if (err_pulse !== 1'b0) begin errors++; $display("FAIL reset_err_pulse got=%b exp=0", err_pulse); end
    checks++; if ({push_data, push_offset, push_size} !== 37'd0) begin
      errors++; $display("FAIL reset_push_regs got=%h/%h/%h exp=0", push_data, push_offset, push_size); end
`ifdef CFS_MD_RX_ERR_CNT_EN
    checks++; if (err_cnt !== 2'd0) begin errors++; $display("FAIL reset_err_cnt got=%0d exp=0", err_cnt); end
`endif
  endtask

  // Legal transfer with push_ready already high: push at N+1, md_ready at N+2.
  task automatic do_legal(input string nm, input logic [31:0] d, input logic [1:0] off, input logic [2:0] sz);
    push_ready = 1'b1;
    start(d, off, sz);
    cyc();
    md_valid = 1'b0;
    checks++; if (push_valid !== 1'b1 || md_ready !== 1'b0) begin
      errors++; $display("FAIL %s_push got push_valid=%b md_ready=%b exp 1/0", nm, push_valid, md_ready); end
    checks++; if (push_data !== d || push_offset !== off || push_size !== sz) begin
      errors++; $display("FAIL %s_fields got=%h/%0d/%0d exp=%h/%0d/%0d", nm, push_data, push_offset, push_size, d, off, sz); end
    cyc();
    checks++; if (md_ready !== 1'b1 || md_err !== 1'b0 || err_pulse !== 1'b0 || push_valid !== 1'b0) begin
      errors++; $display("FAIL %s_resp got rdy=%b err=%b pulse=%b pv=%b exp 1/0/0/0", nm, md_ready, md_err, err_pulse, push_valid); end
    cyc();
    checks++; if (md_ready !== 1'b0 || md_err !== 1'b0) begin
      errors++; $display("FAIL %s_idle got rdy=%b err=%b exp 0/0", nm, md_ready, md_err); end
  endtask

  // Illegal transfer: no push, md_ready/md_err/err_pulse at N+1 for one cycle.
  task automatic do_illegal(input string nm, input logic [1:0] off, input logic [2:0] sz);
    push_ready = 1'b1;
    start(32'hDEAD_0000 | {28'd0, off, sz[1:0]}, off, sz);
    cyc();
    md_valid = 1'b0;
    checks++; if (push_valid !== 1'b0 || md_ready !== 1'b1 || md_err !== 1'b1 || err_pulse !== 1'b1) begin
      errors++; $display("FAIL %s_resp got pv=%b rdy=%b err=%b pulse=%b exp 0/1/1/1", nm, push_valid, md_ready, md_err, err_pulse); end
    cyc();
    checks++; if (md_ready !== 1'b0 || md_err !== 1'b0 || err_pulse !== 1'b0 || push_valid !== 1'b0) begin
      errors++; $display("FAIL %s_idle got rdy=%b err=%b pulse=%b pv=%b exp 0", nm, md_ready, md_err, err_pulse, push_valid); end
  endtask

  task automatic test_legal();
    do_legal("off1_sz1", 32'hA5A5_1234, 2'd1, 3'd1);
    do_legal("off2_sz2", 32'h0BAD_F00D, 2'd2, 3'd2);
    do_legal("off3_sz1", 32'h1357_9BDF, 2'd3, 3'd1);
  endtask

  task automatic test_illegal();
    do_illegal("misalign_off1_sz2", 2'd1, 3'd2);
`ifdef CFS_MD_RX_ERR_CNT_EN
    err_cnt_clr = 1'b1;
    cyc();
    err_cnt_clr = 1'b0;
    checks++; if (err_cnt !== 2'd0) begin errors++; $display("FAIL err_cnt_clr got=%0d exp=0", err_cnt); end
`endif
    do_illegal("overrun_off2_sz3", 2'd2, 3'd3);
    do_illegal("zero_size", 2'd0, 3'd0);
`ifdef CFS_MD_RX_ERR_CNT_EN
    checks++; if (err_cnt !== 2'd2) begin errors++; $display("FAIL err_cnt_two got=%0d exp=2", err_cnt); end
`endif
    do_illegal("overrun_off3_sz4", 2'd3, 3'd4);
  endtask

  // push_ready held low: push_valid must hold stable, inputs outside IDLE are ignored.
  task automatic test_stall();
    push_ready = 1'b0;
    start(32'hCAFE_BABE, 2'd0, 3'd4);
    cyc();
    md_valid = 1'b1;
    md_data = 32'h1111_1111; md_offset = 2'd1; md_size = 3'd2;
    for (int i = 0; i < 5; i++) begin
      checks++; if (push_valid !== 1'b1 || md_ready !== 1'b0 || push_data !== 32'hCAFE_BABE ||
                    push_offset !== 2'd0 || push_size !== 3'd4) begin
        errors++; $display("FAIL stall_cyc%0d got pv=%b rdy=%b %h/%0d/%0d exp 1/0 cafebabe/0/4",
                           i, push_valid, md_ready, push_data, push_offset, push_size); end
      if (i < 4) cyc();
    end
    push_ready = 1'b1;
    cyc();
    md_valid = 1'b0;
    checks++; if (md_ready !== 1'b1 || md_err !== 1'b0 || push_valid !== 1'b0) begin
      errors++; $display("FAIL stall_resp got rdy=%b err=%b pv=%b exp 1/0/0", md_ready, md_err, push_valid); end
    cyc();
    checks++; if (md_ready !== 1'b0 || push_valid !== 1'b0) begin
      errors++; $display("FAIL stall_idle got rdy=%b pv=%b exp 0/0", md_ready, push_valid); end
  endtask

  task automatic test_reset_mid();
    push_ready = 1'b0;
    start(32'h7777_8888, 2'd2, 3'd2);
    cyc();
    md_valid = 1'b0;
    checks++; if (push_valid !== 1'b1) begin errors++; $display("FAIL rmid_push got=%b exp=1", push_valid); end
    #2 reset = 1'b1;
    #1;
    checks++; if (push_valid !== 1'b0 || md_ready !== 1'b0 || push_data !== 32'd0) begin
      errors++; $display("FAIL rmid_async got pv=%b rdy=%b data=%h exp 0/0/0", push_valid, md_ready, push_data); end
    push_ready = 1'b1;
    cyc();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      checks++; if (md_ready !== 1'b0 || push_valid !== 1'b0) begin
        errors++; $display("FAIL rmid_quiet%0d got rdy=%b pv=%b exp 0/0", i, md_ready, push_valid); end
    end
    do_legal("after_reset", 32'h2468_ACE0, 2'd2, 3'd2);
  endtask

  // Illegal then legal with md_valid held through RESP: accepted in the following IDLE.
  task automatic test_back_to_back();
    push_ready = 1'b1;
    start(32'h0, 2'd1, 3'd3);
    cyc();
    checks++; if (md_ready !== 1'b1 || md_err !== 1'b1) begin
      errors++; $display("FAIL b2b_first got rdy=%b err=%b exp 1/1", md_ready, md_err); end
    start(32'h5A5A_C3C3, 2'd0, 3'd2);
    cyc();
    checks++; if (md_ready !== 1'b0 || push_valid !== 1'b0) begin
      errors++; $display("FAIL b2b_idle got rdy=%b pv=%b exp 0/0", md_ready, push_valid); end
    cyc();
    md_valid = 1'b0;
    checks++; if (push_valid !== 1'b1 || push_data !== 32'h5A5A_C3C3 || push_size !== 3'd2) begin
      errors++; $display("FAIL b2b_push got pv=%b data=%h size=%0d exp 1/5a5ac3c3/2", push_valid, push_data, push_size); end
    cyc();
    checks++; if (md_ready !== 1'b1 || md_err !== 1'b0) begin
      errors++; $display("FAIL b2b_resp got rdy=%b err=%b exp 1/0", md_ready, md_err); end
    cyc();
  endtask

`ifdef CFS_MD_RX_ERR_CNT_EN
  task automatic test_err_cnt_sat();
    err_cnt_clr = 1'b1;
    cyc();
    err_cnt_clr = 1'b0;
    for (int i = 0; i < 5; i++) begin
      do_illegal("sat", 2'd1, 3'd2);
      checks++; if (err_cnt !== ((i < 3) ? 2'(i + 1) : 2'd3)) begin
        errors++; $display("FAIL err_cnt_sat%0d got=%0d exp=%0d", i, err_cnt, (i < 3) ? i + 1 : 3); end
    end
    push_ready = 1'b1;
    start(32'h0, 2'd0, 3'd0);
    cyc();
    md_valid = 1'b0;
    err_cnt_clr = 1'b1;
    checks++; if (err_pulse !== 1'b1) begin errors++; $display("FAIL clr_pulse got=%b exp=1", err_pulse); end
    cyc();
    err_cnt_clr = 1'b0;
    checks++; if (err_cnt !== 2'd0) begin errors++; $display("FAIL clr_wins got=%0d exp=0", err_cnt); end
  endtask
`endif

  initial begin
    reset = 1'b1;
    md_valid = 1'b0; md_data = '0; md_offset = '0; md_size = '0;
    push_ready = 1'b0;
`ifdef CFS_MD_RX_ERR_CNT_EN
    err_cnt_clr = 1'b0;
`endif
    #1;
    test_reset();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    cyc();
    test_legal();
    test_illegal();
    test_stall();
    test_reset_mid();
    test_back_to_back();
`ifdef CFS_MD_RX_ERR_CNT_EN
    test_err_cnt_sat();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
